// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings for the ID-stage redirect controller: FSM states, redirect
// kinds, PC mux selects and the decode-flag priority helper.
package pc_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_HALTED   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        KIND_J  = 2'b00,
        KIND_JR = 2'b01,
        KIND_BR = 2'b10
    } kind_e;

    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_TGT = 1'b1;

    typedef struct packed {
        logic  halt;
        logic  redirect;
        kind_e kind;
    } decode_t;

    // Priority: halt > jump_reg > jump > branch_taken.
    function automatic decode_t decode_flags(input logic halt,
                                             input logic jump_reg,
                                             input logic jump,
                                             input logic branch_taken);
        decode_t d;
        d.halt     = halt;
        d.redirect = 1'b0;
        d.kind     = KIND_J;
        if (!halt) begin
            if (jump_reg) begin
                d.redirect = 1'b1;
                d.kind     = KIND_JR;
            end else if (jump) begin
                d.redirect = 1'b1;
                d.kind     = KIND_J;
            end else if (branch_taken) begin
                d.redirect = 1'b1;
                d.kind     = KIND_BR;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_target_reg.sv
// Enable-gated capture register for the redirect target and its kind.
module redirect_target_reg
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned PC_SIZE = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               load,
    input  logic [PC_SIZE-1:0] d_target,
    input  kind_e              d_kind,
    output logic [PC_SIZE-1:0] q_target,
    output kind_e              q_kind
);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            q_target <= '0;
            q_kind   <= KIND_J;
        end else if (load) begin
            q_target <= d_target;
            q_kind   <= d_kind;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ID-stage redirect sequencer: detects J/JR/branch/HALT, freezes the PC for one
// cycle, reloads it with the captured target, flushes IF/ID and counts redirects.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int unsigned PC_SIZE    = 32,
    parameter int unsigned COUNT_SIZE = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_stall,
    input  logic                  i_jump,
    input  logic                  i_jump_reg,
    input  logic                  i_branch_taken,
    input  logic                  i_halt,
    input  logic [PC_SIZE-1:0]    i_jump_addr,
    input  logic [PC_SIZE-1:0]    i_reg_addr,
    input  logic [PC_SIZE-1:0]    i_branch_addr,
    output logic                  o_jump_calc_en,
    output logic                  o_pc_sel,
    output logic [PC_SIZE-1:0]    o_target_addr,
    output logic                  o_pc_write,
    output logic                  o_ifid_flush,
    output logic                  o_halted,
    output logic [COUNT_SIZE-1:0] o_redirect_count
);

    state_e               state;
    decode_t              dec;
    logic                 run_go;
    logic                 detect;
    logic                 halt_go;
    logic                 apply;
    logic [PC_SIZE-1:0]   cap_target;
    kind_e                cap_kind;
    logic [PC_SIZE-1:0]   redirect_target;
    logic [PC_SIZE-1:0]   last_target;
    logic [COUNT_SIZE-1:0] count;

    assign dec     = decode_flags(i_halt, i_jump_reg, i_jump, i_branch_taken);
    assign run_go  = (state == ST_RUN) && i_enable && !i_stall;
    assign detect  = run_go && dec.redirect;
    assign halt_go = run_go && dec.halt;
    assign apply   = (state == ST_REDIRECT) && i_enable;

    // J targets come from the registered jump adder one cycle after the enable.
    assign redirect_target = (cap_kind == KIND_J) ? i_jump_addr : cap_target;

    redirect_target_reg #(
        .PC_SIZE (PC_SIZE)
    ) u_target_reg (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .load     (detect),
        .d_target ((dec.kind == KIND_JR) ? i_reg_addr : i_branch_addr),
        .d_kind   (dec.kind),
        .q_target (cap_target),
        .q_kind   (cap_kind)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_RUN;
            count       <= '0;
            last_target <= '0;
        end else if (i_enable) begin
            case (state)
                ST_RUN: begin
                    if (halt_go)
                        state <= ST_HALTED;
                    else if (detect)
                        state <= ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    state       <= ST_RUN;
                    count       <= count + COUNT_SIZE'(1);
                    last_target <= redirect_target;
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // Output decode; everything forced low while reset is asserted.
    always_comb begin
        o_jump_calc_en = 1'b0;
        o_pc_sel       = PC_SEL_SEQ;
        o_target_addr  = last_target;
        o_pc_write     = 1'b0;
        o_ifid_flush   = 1'b0;
        o_halted       = 1'b0;
        if (i_reset) begin
            o_target_addr = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (run_go) begin
                        if (dec.halt || dec.redirect) begin
                            o_ifid_flush   = 1'b1;
                            o_jump_calc_en = detect && (dec.kind == KIND_J);
                        end else begin
                            o_pc_write = 1'b1;
                        end
                    end
                end
                ST_REDIRECT: begin
                    o_pc_sel      = PC_SEL_TGT;
                    o_target_addr = redirect_target;
                    o_pc_write    = i_enable;
                    o_ifid_flush  = i_enable;
                end
                ST_HALTED: begin
                    o_halted     = 1'b1;
                    o_ifid_flush = i_enable;
                end
                default: ;
            endcase
        end
    end

    assign o_redirect_count = count;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl; a second instance with a
// 4-bit counter shares the stimulus to exercise counter wrap.
module tb_pc_redirect_ctrl;

    typedef struct packed {
        logic        rst, en, st, j, jr, br, h;
        logic [31:0] ja, ra, ba;
    } in_t;

    typedef struct packed {
        logic        pw, sel, fl, ce, ha;
        logic [31:0] tgt;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b1, st = 1'b0;
    logic        j = 1'b0, jr = 1'b0, br = 1'b0, h = 1'b0;
    logic [31:0] ja = '0, ra = '0, ba = '0;

    logic        calc_en, pc_sel, pc_write, flush, halted;
    logic [31:0] target;
    logic [15:0] count;
    logic        s_calc_en, s_pc_sel, s_pc_write, s_flush, s_halted;
    logic [31:0] s_target;
    logic [3:0]  s_count;

    int tests  = 0;
    int failed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_redirect_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_stall(st),
        .i_jump(j), .i_jump_reg(jr), .i_branch_taken(br), .i_halt(h),
        .i_jump_addr(ja), .i_reg_addr(ra), .i_branch_addr(ba),
        .o_jump_calc_en(calc_en), .o_pc_sel(pc_sel), .o_target_addr(target),
        .o_pc_write(pc_write), .o_ifid_flush(flush), .o_halted(halted),
        .o_redirect_count(count)
    );

    pc_redirect_ctrl #(.PC_SIZE(32), .COUNT_SIZE(4)) dut_small (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_stall(st),
        .i_jump(j), .i_jump_reg(jr), .i_branch_taken(br), .i_halt(h),
        .i_jump_addr(ja), .i_reg_addr(ra), .i_branch_addr(ba),
        .o_jump_calc_en(s_calc_en), .o_pc_sel(s_pc_sel), .o_target_addr(s_target),
        .o_pc_write(s_pc_write), .o_ifid_flush(s_flush), .o_halted(s_halted),
        .o_redirect_count(s_count)
    );

    function automatic in_t N(logic r, logic e, logic s, logic fj, logic fjr,
                              logic fbr, logic fh, logic [31:0] a_j,
                              logic [31:0] a_r, logic [31:0] a_b);
        in_t v;
        v.rst = r; v.en = e; v.st = s; v.j = fj; v.jr = fjr; v.br = fbr; v.h = fh;
        v.ja = a_j; v.ra = a_r; v.ba = a_b;
        return v;
    endfunction

    function automatic exp_t E(logic pw, logic sel, logic fl, logic ce, logic ha,
                               logic [31:0] tgt, logic [15:0] cnt);
        exp_t v;
        v.pw = pw; v.sel = sel; v.fl = fl; v.ce = ce; v.ha = ha;
        v.tgt = tgt; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        chk("pc_write",   32'(pc_write), 32'(e.pw));
        chk("pc_sel",     32'(pc_sel),   32'(e.sel));
        chk("ifid_flush", 32'(flush),    32'(e.fl));
        chk("calc_en",    32'(calc_en),  32'(e.ce));
        chk("halted",     32'(halted),   32'(e.ha));
        chk("target",     target,        e.tgt);
        chk("count",      32'(count),    32'(e.cnt));
        chk("s_pc_write", 32'(s_pc_write), 32'(e.pw));
        chk("s_pc_sel",   32'(s_pc_sel),   32'(e.sel));
        chk("s_flush",    32'(s_flush),    32'(e.fl));
        chk("s_calc_en",  32'(s_calc_en),  32'(e.ce));
        chk("s_halted",   32'(s_halted),   32'(e.ha));
        chk("s_target",   s_target,        e.tgt);
        chk("s_count4",   32'(s_count),    32'(e.cnt[3:0]));
    endtask

    // Drive at negedge, push expectation, sample 2ns later (before posedge).
    task automatic step(input in_t v, input exp_t e);
        @(negedge clk);
        rst = v.rst; en = v.en; st = v.st;
        j = v.j; jr = v.jr; br = v.br; h = v.h;
        ja = v.ja; ra = v.ra; ba = v.ba;
        sb.push_back(e);
        #2;
        compare_pop();
    endtask

    initial begin
        // Reset: outputs low even with a jump flag present
        step(N(1,1,0,1,0,0,0, 32'h0,   32'h0,   32'h0),   E(0,0,0,0,0, 32'h0, 16'd0));
        step(N(1,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(0,0,0,0,0, 32'h0, 16'd0));
        // Idle fetch
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h0, 16'd0));
        // J: detect then redirect to 0x40
        step(N(0,1,0,1,0,0,0, 32'h40,  32'h0,   32'h0),   E(0,0,1,1,0, 32'h0, 16'd0));
        step(N(0,1,0,0,0,0,0, 32'h40,  32'h0,   32'h0),   E(1,1,1,0,0, 32'h40, 16'd0));
        step(N(0,1,0,0,0,0,0, 32'h40,  32'h0,   32'h0),   E(1,0,0,0,0, 32'h40, 16'd1));
        // JR with branch also asserted: JR target wins, later rs change ignored
        step(N(0,1,0,0,1,1,0, 32'h0,   32'h100, 32'h200), E(0,0,1,0,0, 32'h40, 16'd1));
        step(N(0,1,0,0,0,0,0, 32'hdead, 32'h999, 32'h0),  E(1,1,1,0,0, 32'h100, 16'd1));
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h100, 16'd2));
        // Branch under 2-cycle stall
        step(N(0,1,1,0,0,1,0, 32'h0,   32'h0,   32'h20),  E(0,0,0,0,0, 32'h100, 16'd2));
        step(N(0,1,1,0,0,1,0, 32'h0,   32'h0,   32'h20),  E(0,0,0,0,0, 32'h100, 16'd2));
        step(N(0,1,0,0,0,1,0, 32'h0,   32'h0,   32'h20),  E(0,0,1,0,0, 32'h100, 16'd2));
        step(N(0,1,1,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,1,1,0,0, 32'h20, 16'd2));
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h20, 16'd3));
        // J, then enable low for 3 cycles in REDIRECT
        step(N(0,1,0,1,0,0,0, 32'h0,   32'h0,   32'h0),   E(0,0,1,1,0, 32'h20, 16'd3));
        for (int k = 0; k < 3; k++)
            step(N(0,0,0,0,0,0,0, 32'h80, 32'h0, 32'h0),  E(0,1,0,0,0, 32'h80, 16'd3));
        step(N(0,1,0,0,0,0,0, 32'h80,  32'h0,   32'h0),   E(1,1,1,0,0, 32'h80, 16'd3));
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h80, 16'd4));
        // Enable low in RUN masks detection
        step(N(0,0,0,1,0,0,0, 32'h0,   32'h0,   32'h0),   E(0,0,0,0,0, 32'h80, 16'd4));
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h80, 16'd4));
        // HALT beats jump; stays halted despite flags
        step(N(0,1,0,1,0,0,1, 32'h0,   32'h0,   32'h0),   E(0,0,1,0,0, 32'h80, 16'd4));
        for (int k = 0; k < 11; k++)
            step(N(0,1,0,1,1,1,0, 32'h0, 32'h0, 32'h0),   E(0,0,1,0,1, 32'h80, 16'd4));
        step(N(1,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(0,0,0,0,0, 32'h0, 16'd4));
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h0, 16'd0));
        // 16 branch redirects: 4-bit counter wraps to 0
        for (int k = 0; k < 16; k++) begin
            step(N(0,1,0,0,0,1,0, 32'h0, 32'h0, 32'h1000 + 32'(k*4)),
                 E(0,0,1,0,0, (k == 0) ? 32'h0 : 32'h1000 + 32'((k-1)*4), 16'(k)));
            step(N(0,1,0,0,0,0,0, 32'h0, 32'h0, 32'h0),
                 E(1,1,1,0,0, 32'h1000 + 32'(k*4), 16'(k)));
        end
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h103c, 16'd16));
        // Reset while in REDIRECT: no PC load, back to RUN
        step(N(0,1,0,0,0,1,0, 32'h0,   32'h0,   32'h3000), E(0,0,1,0,0, 32'h103c, 16'd16));
        step(N(1,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(0,0,0,0,0, 32'h0, 16'd16));
        step(N(0,1,0,0,0,0,0, 32'h0,   32'h0,   32'h0),   E(1,0,0,0,0, 32'h0, 16'd0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
